// File: rtl/fpu_cmp_sched_pkg.sv
// Shared encodings and types for the FP compare scheduler.
package fpu_cmp_sched_pkg;

  localparam logic [1:0] OP_LT = 2'b00;
  localparam logic [1:0] OP_LE = 2'b01;
  localparam logic [1:0] OP_EQ = 2'b10;

  localparam int ID_W = 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } pipe_entry_t;

endpackage

// File: rtl/cmp_res_fifo.sv
// First-word-fall-through result FIFO, 32-bit entries, with occupancy count.
module cmp_res_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [31:0]                    push_data,
  input  logic                           pop,
  output logic                           out_valid,
  output logic [31:0]                    out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign do_pop    = pop & out_valid;

  // When full, wr_ptr aliases rd_ptr; the head is read before the edge, so a
  // simultaneous push and pop at full is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fpu_cmp_sched.sv
// Round-robin, credit-based sharing of one pipelined FP comparator between
// two requesters, with per-requester FWFT result FIFOs.
module fpu_cmp_sched
  import fpu_cmp_sched_pkg::*;
#(
  parameter int CMP_LAT = 1,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [1:0]  r0_op,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  output logic        r0_res_valid,
  input  logic        r0_res_ready,
  output logic [31:0] r0_res_data,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [1:0]  r1_op,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        r1_res_valid,
  input  logic        r1_res_ready,
  output logic [31:0] r1_res_data,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  output logic        cmp_is_eq,
  output logic        cmp_is_le,
  input  logic [31:0] cmp_q
);

  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] inflight0, inflight1;
  logic [CW-1:0] count0, count1;
  logic [CW:0]   out0, out1;
  logic          pop0, pop1;
  logic          elig0, elig1;
  logic          req0, req1;
  logic          grant0, grant1;
  logic          last_gnt;
  logic          cap0, cap1;
  logic          cmp_q_unused;
  pipe_entry_t   pipe [CMP_LAT+1];

  assign cmp_q_unused = ^cmp_q[31:1];

  assign pop0 = r0_res_valid & r0_res_ready;
  assign pop1 = r1_res_valid & r1_res_ready;
  assign out0 = {1'b0, inflight0} + {1'b0, count0};
  assign out1 = {1'b0, inflight1} + {1'b0, count1};

  // A slot freed by a pop this cycle can be reused by a grant this cycle.
  assign elig0 = (out0 < (CW+1)'(DEPTH)) | pop0;
  assign elig1 = (out1 < (CW+1)'(DEPTH)) | pop1;

  // Handshake: a request transfers on the edge where valid & ready are both
  // high; ready may depend on valid, never the reverse; payload is held until
  // accepted. Results use the same rule on res_valid/res_ready.
  always_comb begin
    req0   = r0_valid & elig0 & ~rst;
    req1   = r1_valid & elig1 & ~rst;
    grant0 = req0 & (~req1 | last_gnt);
    grant1 = req1 & (~req0 | ~last_gnt);
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  assign cap0 = pipe[CMP_LAT].valid & (pipe[CMP_LAT].id == ID_W'(0));
  assign cap1 = pipe[CMP_LAT].valid & (pipe[CMP_LAT].id == ID_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_is_eq <= 1'b0;
      cmp_is_le <= 1'b0;
      inflight0 <= '0;
      inflight1 <= '0;
      for (int k = 0; k <= CMP_LAT; k++) pipe[k] <= '0;
    end else begin
      if (grant0 | grant1) begin
        last_gnt  <= grant1;
        cmp_a     <= grant1 ? r1_a : r0_a;
        cmp_b     <= grant1 ? r1_b : r0_b;
        cmp_is_eq <= grant1 ? r1_op[1] : r0_op[1];
        cmp_is_le <= grant1 ? r1_op[0] : r0_op[0];
      end
      pipe[0].valid <= grant0 | grant1;
      pipe[0].id    <= ID_W'(grant1);
      for (int k = 1; k <= CMP_LAT; k++) pipe[k] <= pipe[k-1];
      inflight0 <= inflight0 + CW'(grant0) - CW'(cap0);
      inflight1 <= inflight1 + CW'(grant1) - CW'(cap1);
    end
  end

  cmp_res_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (cap0),
    .push_data ({31'b0, cmp_q[0]}),
    .pop       (r0_res_ready),
    .out_valid (r0_res_valid),
    .out_data  (r0_res_data),
    .count     (count0)
  );

  cmp_res_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (cap1),
    .push_data ({31'b0, cmp_q[0]}),
    .pop       (r1_res_ready),
    .out_valid (r1_res_valid),
    .out_data  (r1_res_data),
    .count     (count1)
  );

endmodule

// File: tb/tb_fpu_cmp_sched.sv
// Bench for fpu_cmp_sched: comparator stub, transaction-level model with
// per-cycle compare, and directed scenarios with literal expectations.
module tb_fpu_cmp_sched;

  localparam int CMP_LAT = 1;
  localparam int DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [1:0]  r0_op = '0, r1_op = '0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic        r0_res_valid, r1_res_valid;
  logic        r0_res_ready = 1'b1, r1_res_ready = 1'b1;
  logic [31:0] r0_res_data, r1_res_data;
  logic [31:0] cmp_a, cmp_b, cmp_q;
  logic        cmp_is_eq, cmp_is_le;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pop_cnt0 = 0;
  int pop_cnt1 = 0;

  fpu_cmp_sched #(.CMP_LAT(CMP_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_res_valid(r0_res_valid), .r0_res_ready(r0_res_ready), .r0_res_data(r0_res_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_res_valid(r1_res_valid), .r1_res_ready(r1_res_ready), .r1_res_data(r1_res_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_is_eq(cmp_is_eq), .cmp_is_le(cmp_is_le),
    .cmp_q(cmp_q)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timed out");
  end

  // ---------------- comparator semantics ----------------
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  function automatic logic fp_cmp(input logic [31:0] a, input logic [31:0] b,
                                  input logic is_eq, input logic is_le);
    logic lt;
    lt = fkey(a) < fkey(b);
    if (is_eq) return a == b;
    if (is_le) return lt | (a == b);
    return lt;
  endfunction

  logic stg [CMP_LAT];
  always @(posedge clk) begin
    stg[0] <= fp_cmp(cmp_a, cmp_b, cmp_is_eq, cmp_is_le);
    for (int k = 1; k < CMP_LAT; k++) stg[k] <= stg[k-1];
  end
  assign cmp_q = {31'b0, stg[CMP_LAT-1]};

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard model ----------------
  // Each entry: {cycle the result becomes visible, flag}.
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          last_m = 1;
  logic [31:0] e_a = '0, e_b = '0;
  logic        e_eq = 1'b0, e_le = 1'b0;

  always @(negedge clk) begin
    logic v0, v1, p0, p1, el0, el1, q0, q1, g0, g1;
    if (rst) begin
      check("rst_r0_ready", 32'(r0_ready), 0);
      check("rst_r1_ready", 32'(r1_ready), 0);
      check("rst_r0_res_valid", 32'(r0_res_valid), 0);
      check("rst_r1_res_valid", 32'(r1_res_valid), 0);
      check("rst_r0_res_data", r0_res_data, 0);
      check("rst_r1_res_data", r1_res_data, 0);
      check("rst_cmp_a", cmp_a, 0);
      check("rst_cmp_b", cmp_b, 0);
      check("rst_cmp_flags", {30'b0, cmp_is_eq, cmp_is_le}, 0);
      exp_q0.delete();
      exp_q1.delete();
      last_m = 1;
      e_a = '0; e_b = '0; e_eq = 1'b0; e_le = 1'b0;
    end else begin
      v0 = (exp_q0.size() > 0) && (int'(exp_q0[0][32:1]) <= cyc);
      v1 = (exp_q1.size() > 0) && (int'(exp_q1[0][32:1]) <= cyc);
      p0 = v0 & r0_res_ready;
      p1 = v1 & r1_res_ready;
      el0 = (exp_q0.size() < DEPTH) | p0;
      el1 = (exp_q1.size() < DEPTH) | p1;
      q0 = r0_valid & el0;
      q1 = r1_valid & el1;
      g0 = q0 & (!q1 || last_m == 1);
      g1 = q1 & (!q0 || last_m == 0);
      check("r0_ready", 32'(r0_ready), 32'(g0));
      check("r1_ready", 32'(r1_ready), 32'(g1));
      check("r0_res_valid", 32'(r0_res_valid), 32'(v0));
      check("r1_res_valid", 32'(r1_res_valid), 32'(v1));
      if (v0) check("r0_res_data", r0_res_data, {31'b0, exp_q0[0][0]});
      if (v1) check("r1_res_data", r1_res_data, {31'b0, exp_q1[0][0]});
      check("cmp_a", cmp_a, e_a);
      check("cmp_b", cmp_b, e_b);
      check("cmp_flags", {30'b0, cmp_is_eq, cmp_is_le}, {30'b0, e_eq, e_le});
      check("fifo0_bound", 32'(32'(dut.u_fifo0.count) <= DEPTH), 1);
      check("fifo1_bound", 32'(32'(dut.u_fifo1.count) <= DEPTH), 1);
      if (r0_res_valid && r0_res_ready) pop_cnt0++;
      if (r1_res_valid && r1_res_ready) pop_cnt1++;
      if (p0) void'(exp_q0.pop_front());
      if (p1) void'(exp_q1.pop_front());
      if (g0) begin
        exp_q0.push_back({32'(cyc + 2 + CMP_LAT), fp_cmp(r0_a, r0_b, r0_op[1], r0_op[0])});
        e_a = r0_a; e_b = r0_b; e_eq = r0_op[1]; e_le = r0_op[0];
        last_m = 0;
      end
      if (g1) begin
        exp_q1.push_back({32'(cyc + 2 + CMP_LAT), fp_cmp(r1_a, r1_b, r1_op[1], r1_op[0])});
        e_a = r1_a; e_b = r1_b; e_eq = r1_op[1]; e_le = r1_op[0];
        last_m = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int r, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, output int waits);
    logic rdy;
    if (r == 0) begin r0_op = op; r0_a = a; r0_b = b; r0_valid = 1'b1; end
    else        begin r1_op = op; r1_a = a; r1_b = b; r1_valid = 1'b1; end
    waits = 0;
    while (1) begin
      @(negedge clk);
      rdy = (r == 0) ? r0_ready : r1_ready;
      if (rdy) break;
      waits++;
      if (waits > 40) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    if (r == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  // Called right after send returns; checks issue flags and result latency.
  task automatic lat_check(input int r, input logic eq, input logic le, input logic [31:0] exp);
    @(negedge clk);
    check("lat_cmp_is_eq", 32'(cmp_is_eq), 32'(eq));
    check("lat_cmp_is_le", 32'(cmp_is_le), 32'(le));
    @(negedge clk);
    check("lat_early_valid", 32'(r == 0 ? r0_res_valid : r1_res_valid), 0);
    @(negedge clk);
    check("lat_valid", 32'(r == 0 ? r0_res_valid : r1_res_valid), 1);
    check("lat_data", (r == 0) ? r0_res_data : r1_res_data, exp);
  endtask

  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] FM3 = 32'hC040_0000;

  // ---------------- directed scenarios ----------------
  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("model_lt_1_2", 32'(fp_cmp(F1, F2, 1'b0, 1'b0)), 1);
    check("model_le_2_1", 32'(fp_cmp(F2, F1, 1'b0, 1'b1)), 0);

    // single LT on r0
    send(0, 2'b00, F1, F2, w);
    check("s1_wait", 32'(w), 0);
    lat_check(0, 1'b0, 1'b0, 32'h1);
    repeat (4) @(posedge clk); #1;

    // contention: both streaming, grants alternate
    fork
      for (int i = 0; i < 4; i++) send(0, 2'b10, F2, F2, w);
      for (int i = 0; i < 4; i++) send(1, 2'b00, F2, F1, w);
    join
    repeat (8) @(posedge clk); #1;

    // backpressure on r0 while r1 keeps issuing
    r0_res_ready = 1'b0;
    fork
      begin
        send(0, 2'b01, F1, F1, w);
        send(0, 2'b01, F2, F1, w);
        send(0, 2'b11, FM3, FM3, w);
      end
      begin
        send(1, 2'b01, F1, F2, w);
        send(1, 2'b10, F1, F2, w);
      end
      begin
        repeat (10) @(negedge clk);
        check("bp_r0_blocked", 32'(r0_ready), 0);
        check("bp_r0_still_valid", 32'(r0_valid), 1);
        check("bp_r0_head_valid", 32'(r0_res_valid), 1);
        check("bp_r0_head_data", r0_res_data, 32'h1);
        @(posedge clk); #1;
        r0_res_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #1;

    // full FIFO, then pop and grant in the same cycle
    r0_res_ready = 1'b0;
    send(0, 2'b00, F1, F2, w);
    send(0, 2'b00, F2, F1, w);
    repeat (5) @(posedge clk); #1;
    r0_res_ready = 1'b1;
    send(0, 2'b10, F2, F2, w);
    check("full_pop_grant_wait", 32'(w), 0);
    repeat (8) @(posedge clk); #1;

    // reset with an operation in flight
    send(0, 2'b00, F1, F2, w);
    rst = 1'b1;
    r0_valid = 1'b1;
    @(negedge clk);
    check("rst_gates_ready", 32'(r0_ready), 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    r0_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_stale_result", 32'(r0_res_valid), 0);
    @(posedge clk); #1;
    send(0, 2'b00, F1, F2, w);
    lat_check(0, 1'b0, 1'b0, 32'h1);
    repeat (4) @(posedge clk); #1;

    // op encodings
    send(1, 2'b11, FM3, FM3, w);
    lat_check(1, 1'b1, 1'b1, 32'h1);
    repeat (2) @(posedge clk); #1;
    send(0, 2'b01, F1, F1, w);
    lat_check(0, 1'b0, 1'b1, 32'h1);
    repeat (2) @(posedge clk); #1;
    send(0, 2'b01, F2, F1, w);
    lat_check(0, 1'b0, 1'b1, 32'h0);
    repeat (10) @(posedge clk); #1;

    check("total_r0_results", 32'(pop_cnt0), 14);
    check("total_r1_results", 32'(pop_cnt1), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
